acs_pm_bank: RTL and testbench
==============================

Name: acs_pm_bank

Overview:
- Add-compare-select stage with path-metric storage for the 4-state (K=3) Viterbi trellis.
- Sits directly downstream of the branch-metric units. Each accepted symbol consumes eight branch metrics and updates four path metrics.
- Emits one decision bit per state to the traceback/survivor stage, plus the best-metric state.
- Renormalizes metrics so the fixed-width registers never overflow.

Parameters:
- PM_W, 8, path-metric width in bits (legal range 5..16).
- BM_W, 2, branch-metric width in bits; matches the branch-metric unit output.
- INIT_BIAS, 16, initial metric loaded into states 1..3 on start; state 0 loads 0.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  reinitialize path metrics (new frame).
- in_valid  in  1  bm_in holds a valid symbol's branch metrics.
- in_ready  out  1  block can accept a symbol this cycle.
- bm_in  in  8*BM_W  branch metrics; field i = bm_in[i*BM_W +: BM_W], i = 2*ns + x.
- dec_valid  out  1  dec_bits/best_state/pm_out hold a result.
- out_ready  in  1  downstream accepts the result.
- dec_bits  out  4  bit ns = selected predecessor index x for next state ns.
- best_state  out  2  state with minimum new metric.
- pm_out  out  4*PM_W  current path metrics; field s = pm_out[s*PM_W +: PM_W].

Behaviour:
- Trellis: state s = 2 bits. Next state ns has predecessors p(ns,x) = {ns[0], x}, x in {0,1}. Branch ns<-p(ns,x) uses bm field 2*ns+x.
- Candidate: c_x = pm[p(ns,x)] + bm[2*ns+x], computed at PM_W+1 bits.
- Select: dec_bits[ns] = 1 iff c_1 < c_0 strictly. Ties select x=0.
- best_state = argmin of new metrics; ties resolve to the lowest index.
- Normalization:
  - If the minimum of the four new metrics is >= 2**(PM_W-1), subtract 2**(PM_W-1) from all four before registering.
  - Otherwise store unchanged.
  - Spread is bounded by 4*(2**BM_W-1), so metrics never exceed PM_W bits for legal parameters.
- Handshake:
  - in_ready = !dec_valid || out_ready (combinational).
  - A symbol is accepted when in_valid && in_ready.
  - Latency 1 cycle: on the accepting edge, pm, dec_bits and best_state update and dec_valid is set.
  - dec_valid clears on an edge with out_ready && no accept.
  - Outputs stay stable while dec_valid && !out_ready.
  - Accept and output drain in the same cycle is allowed; dec_valid stays 1 with new data.
- Start:
  - start sampled at a clock edge loads pm = {0, INIT_BIAS, INIT_BIAS, INIT_BIAS} (state 0 first).
  - If a symbol is also accepted on that edge, the ACS uses the freshly initialized metrics, i.e. start takes precedence as initialization and the symbol is processed against it.
  - start without accept: reinit only; dec_valid unchanged (a pending result is still held until drained).
  - start while in_ready=0: metrics reinit, no symbol accepted.
- Reset (rst_n low, any time, asynchronous):
  - pm = {0, INIT_BIAS, INIT_BIAS, INIT_BIAS}, dec_valid=0, dec_bits=0, best_state=0.
  - Any in-flight result is discarded.
- bm_in is ignored when not accepted; no X propagation into pm.

Test Plan:
- Reset then start+in_valid, bm_in all 0, out_ready=1 -> next cycle dec_valid=1, pm_out = {0,16,0,16}, dec_bits=0000, best_state=0.
- Continue with bm all 2, one per cycle:
  - second accepted symbol -> pm all 2;
  - 64th -> all 0x7E;
  - 65th -> all 0x00 (normalized, no wrap).
- From pm all 2: bm fields = {1,1,1,1,1,1,0,2} (field 0 = 2, field 1 = 0, listed high to low) -> dec_bits=0001, pm = {2,3,3,3}, best_state=0.
- Backpressure: out_ready=0 with result held -> in_ready=0, dec_bits/pm_out stable for 5 cycles despite changing bm_in and in_valid=1. Raise out_ready -> exactly one new symbol accepted next edge.
- Assert rst_n low mid-stream between edges -> outputs immediately reset values (pm {0,16,16,16}, dec_valid=0). Release -> first accepted symbol processed from initial metrics.
- start without in_valid while dec_valid=1, out_ready=0 -> pm reinitialized, dec_valid stays 1 and dec_bits unchanged until drained.

Source files
------------

// File: rtl/acs_pm_bank.sv
// Add-compare-select stage with path-metric storage for the 4-state (K=3)
// Viterbi trellis. One symbol (eight branch metrics) per accepted handshake,
// four decision bits plus best state out, metrics renormalized in place.
module acs_pm_bank #(
  parameter int unsigned PM_W      = 8,
  parameter int unsigned BM_W      = 2,
  parameter int unsigned INIT_BIAS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*BM_W-1:0]   bm_in,
  output logic                dec_valid,
  input  logic                out_ready,
  output logic [3:0]          dec_bits,
  output logic [1:0]          best_state,
  output logic [4*PM_W-1:0]   pm_out
);

  // Candidates carry one extra bit so the compare never sees a wrapped sum.
  localparam int unsigned CW = PM_W + 1;
  localparam logic [CW-1:0] HALF = CW'(2 ** (PM_W - 1));
  localparam logic [PM_W-1:0] INIT_PM = PM_W'(INIT_BIAS);
  localparam logic [3:0][PM_W-1:0] INIT_VEC = {INIT_PM, INIT_PM, INIT_PM, PM_W'(0)};

  logic [3:0][PM_W-1:0] pm_q, pm_d;
  logic [3:0][PM_W-1:0] base;
  logic [3:0][PM_W-1:0] pm_new;
  logic                 dec_valid_q, dec_valid_d;
  logic [3:0]           dec_bits_q, dec_bits_d;
  logic [1:0]           best_q, best_d;

  logic [BM_W-1:0]      bm [8];
  logic [CW-1:0]        cand0 [4];
  logic [CW-1:0]        cand1 [4];
  logic [CW-1:0]        newm [4];
  logic [3:0]           sel;
  logic [CW-1:0]        min_m;
  logic [1:0]           min_idx;
  logic [CW-1:0]        sub;
  logic                 accept;

  // Handshake: a held result blocks new symbols unless it drains this cycle.
  always_comb begin
    in_ready = !dec_valid_q || out_ready;
    accept   = in_valid && in_ready;
  end

  // A start on the accepting edge makes the ACS run from fresh metrics.
  always_comb begin
    base = start ? INIT_VEC : pm_q;
  end

  for (genvar i = 0; i < 8; i++) begin : g_bm
    assign bm[i] = bm_in[i*BM_W +: BM_W];
  end

  // Per next state: predecessors {ns[0], x}, ties select x=0.
  for (genvar ns = 0; ns < 4; ns++) begin : g_acs
    localparam int unsigned P0 = 2 * (ns % 2);
    localparam int unsigned P1 = P0 + 1;
    assign cand0[ns]  = CW'(base[P0]) + CW'(bm[2*ns]);
    assign cand1[ns]  = CW'(base[P1]) + CW'(bm[2*ns+1]);
    assign sel[ns]    = cand1[ns] < cand0[ns];
    assign newm[ns]   = sel[ns] ? cand1[ns] : cand0[ns];
    assign pm_new[ns] = PM_W'(newm[ns] - sub);
  end

  // Minimum new metric and its lowest index, then the renormalization offset.
  always_comb begin
    min_m   = newm[0];
    min_idx = 2'd0;
    if (newm[1] < min_m) begin
      min_m   = newm[1];
      min_idx = 2'd1;
    end
    if (newm[2] < min_m) begin
      min_m   = newm[2];
      min_idx = 2'd2;
    end
    if (newm[3] < min_m) begin
      min_m   = newm[3];
      min_idx = 2'd3;
    end
    sub = (min_m >= HALF) ? HALF : '0;
  end

  // Next-state: accept updates everything; start alone only reloads metrics.
  always_comb begin
    pm_d        = pm_q;
    dec_bits_d  = dec_bits_q;
    best_d      = best_q;
    dec_valid_d = dec_valid_q;
    if (accept) begin
      pm_d        = pm_new;
      dec_bits_d  = sel;
      best_d      = min_idx;
      dec_valid_d = 1'b1;
    end else begin
      if (start) begin
        pm_d = INIT_VEC;
      end
      if (out_ready) begin
        dec_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q        <= INIT_VEC;
      dec_valid_q <= 1'b0;
      dec_bits_q  <= '0;
      best_q      <= '0;
    end else begin
      pm_q        <= pm_d;
      dec_valid_q <= dec_valid_d;
      dec_bits_q  <= dec_bits_d;
      best_q      <= best_d;
    end
  end

  assign dec_valid  = dec_valid_q;
  assign dec_bits   = dec_bits_q;
  assign best_state = best_q;
  assign pm_out     = pm_q;

endmodule

// File: tb/tb_acs_pm_bank.sv
// Scoreboard bench for acs_pm_bank: the driver pushes expected results from a
// trellis reference model, a negedge monitor pops and compares them.
module tb_acs_pm_bank;

  localparam int unsigned PM_W = 8;
  localparam int unsigned BM_W = 2;
  localparam int unsigned INIT = 16;
  localparam int HALF_I = 1 << (PM_W - 1);
  localparam logic [31:0] INIT_PACK = {8'(INIT), 8'(INIT), 8'(INIT), 8'h00};

  typedef struct packed {
    logic [3:0]  db;
    logic [1:0]  bs;
    logic [31:0] pm;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bm_in;
  logic        dec_valid;
  logic        out_ready;
  logic [3:0]  dec_bits;
  logic [1:0]  best_state;
  logic [31:0] pm_out;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  int   mpm[4];
  bit   mdv;

  acs_pm_bank #(.PM_W(PM_W), .BM_W(BM_W), .INIT_BIAS(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .bm_in(bm_in), .dec_valid(dec_valid),
    .out_ready(out_ready), .dec_bits(dec_bits), .best_state(best_state),
    .pm_out(pm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_init();
    mpm[0] = 0;
    for (int s = 1; s < 4; s++) mpm[s] = int'(INIT);
  endtask

  // Reference trellis step: pick the cheaper predecessor, renormalize by half.
  task automatic model_accept(input logic [15:0] bm);
    int   f[8];
    int   nm[4];
    int   mn;
    int   bi;
    exp_t e;
    e = '0;
    for (int i = 0; i < 8; i++) f[i] = int'(bm >> (BM_W * i)) & 3;
    for (int ns = 0; ns < 4; ns++) begin
      int a;
      int b;
      a = mpm[2 * (ns % 2)] + f[2 * ns];
      b = mpm[2 * (ns % 2) + 1] + f[2 * ns + 1];
      if (b < a) begin
        nm[ns] = b;
        e.db = e.db | (4'(1) << ns);
      end else begin
        nm[ns] = a;
      end
    end
    mn = nm[0];
    bi = 0;
    for (int s = 1; s < 4; s++) if (nm[s] < mn) begin mn = nm[s]; bi = s; end
    for (int s = 0; s < 4; s++) begin
      if (mn >= HALF_I) nm[s] = nm[s] - HALF_I;
      mpm[s] = nm[s];
      e.pm = e.pm | (32'(nm[s] & 255) << (8 * s));
    end
    e.bs = 2'(bi);
    q.push_back(e);
  endtask

  // One clock of stimulus; returns #1 after the edge that consumes it.
  task automatic cyc(input bit st, input bit iv, input bit ordy, input logic [15:0] bm);
    bit   rdy;
    bit   acc;
    bit   patch;
    exp_t e;
    start = st; in_valid = iv; out_ready = ordy; bm_in = bm;
    #1;
    rdy = !mdv || ordy;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    acc = iv && rdy;
    if (st) model_init();
    if (acc) begin
      model_accept(bm);
      mdv = 1'b1;
    end else if (ordy) begin
      mdv = 1'b0;
    end
    patch = st && !acc;
    @(posedge clk);
    if (patch && q.size() > 0) begin
      e = q[0];
      e.pm = INIT_PACK;
      q[0] = e;
    end
    #1;
  endtask

  // Asynchronous reset asserted between edges, checked before the next edge.
  task automatic reset_mid();
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pm", pm_out, INIT_PACK);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_bits", 32'(dec_bits), 32'd0);
    chk("rst_best", 32'(best_state), 32'd0);
    q.delete();
    model_init();
    mdv = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every held result is compared; it retires when out_ready drains it.
  always @(negedge clk) begin
    if (rst_n && dec_valid) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: dec_bits=%b best=%0d pm=%h with no expected entry",
                 dec_bits, best_state, pm_out);
      end else begin
        if (dec_bits !== q[0].db || best_state !== q[0].bs || pm_out !== q[0].pm) begin
          fails++;
          $display("FAIL result: got dec=%b best=%0d pm=%h expected dec=%b best=%0d pm=%h",
                   dec_bits, best_state, pm_out, q[0].db, q[0].bs, q[0].pm);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bm_in = '0;
    model_init();
    mdv = 1'b0;
    #12;
    chk("reset_pm", pm_out, INIT_PACK);
    chk("reset_dec_valid", 32'(dec_valid), 32'd0);
    chk("reset_dec_bits", 32'(dec_bits), 32'd0);
    chk("reset_best", 32'(best_state), 32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First symbol with start: zero branch metrics.
    cyc(1'b1, 1'b1, 1'b1, 16'h0000);
    chk("first_valid", 32'(dec_valid), 32'd1);
    chk("first_pm", pm_out, 32'h1000_1000);
    chk("first_dec", 32'(dec_bits), 32'd0);
    chk("first_best", 32'(best_state), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 16'hAAAA);
    chk("second_pm", pm_out, 32'h0202_0202);
    cyc(1'b0, 1'b1, 1'b1, 16'h5552);
    chk("sel_pm", pm_out, 32'h0303_0302);
    chk("sel_dec", 32'(dec_bits), 32'd1);
    chk("sel_best", 32'(best_state), 32'd0);

    // Climb to the renormalization threshold.
    cyc(1'b1, 1'b1, 1'b1, 16'h0000);
    for (int k = 2; k <= 65; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 16'hAAAA);
      if (k == 64) chk("pm_7e", pm_out, 32'h7E7E_7E7E);
      if (k == 65) chk("pm_norm", pm_out, 32'h0000_0000);
    end

    // Backpressure: held result must not move.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
      chk("hold_pm", pm_out, 32'h0);
    end
    cyc(1'b0, 1'b1, 1'b1, 16'($urandom));
    cyc(1'b0, 1'b0, 1'b1, 16'h0);
    chk("one_accept_drained", 32'(dec_valid), 32'd0);

    // Start without a symbol while a result is held.
    cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
    cyc(1'b1, 1'b0, 1'b0, 16'($urandom));
    chk("start_only_pm", pm_out, INIT_PACK);
    chk("start_only_valid", 32'(dec_valid), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
    cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
    cyc(1'b0, 1'b0, 1'b1, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 16'($urandom));

    // Mid-stream reset, then resume from initial metrics.
    cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
    reset_mid();
    cyc(1'b0, 1'b1, 1'b1, 16'($urandom));
    cyc(1'b0, 1'b1, 1'b1, 16'($urandom));

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(299, 0) == 0) begin
        reset_mid();
      end else begin
        cyc(1'($urandom_range(15, 0) == 0), 1'($urandom_range(3, 0) != 0),
            1'($urandom_range(2, 0) != 0), 16'($urandom));
      end
    end

    // Drain, bounded.
    for (int n = 0; n < 10 && q.size() > 0; n++) cyc(1'b0, 1'b0, 1'b1, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("final_valid", 32'(dec_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
